// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG raster write-back path.
// Define JPEG_RGB565_EN for 16-bit RGB565 frame-buffer words; otherwise words are 24-bit RGB888.
package jpeg_pkg;

    localparam int MCU_S_444 = 8;
    localparam int MCU_S_420 = 16;

`ifdef JPEG_RGB565_EN
    localparam int PIX_W = 16;
`else
    localparam int PIX_W = 24;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
`ifdef JPEG_RGB565_EN
        return {r[7:3], g[7:2], b[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on rd_data whenever non-empty.
// rd_data reads as zero when empty; a write into a full FIFO is accepted if a read happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_rd;
    logic             w_do_wr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd = rd_en && !w_empty;
    assign w_do_wr = wr_en && (!w_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign full    = w_full;
    assign empty   = w_empty;

endmodule

// File: rtl/mcu_raster_writer.sv
// Converts MCU-ordered pixels into raster-addressed frame-buffer writes through a write FIFO.
// Pixel word format selected by JPEG_RGB565_EN (see jpeg_pkg).
module mcu_raster_writer
    import jpeg_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic              mode_420,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    input  logic              pixel_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int FW = ADDR_W + PIX_W;

    state_t      r_state;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic        r_mode_420;
    logic [16:0] r_mcu_x;
    logic [16:0] r_mcu_y;
    logic [3:0]  r_col;
    logic [3:0]  r_row;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_overflow;

    logic [3:0]    w_s_last;
    logic [16:0]   w_s_step;
    logic [16:0]   w_x;
    logic [16:0]   w_y;
    logic [16:0]   w_next_mcu_x;
    logic [16:0]   w_next_mcu_y;
    logic [33:0]   w_lin;
    logic          w_in_bounds;
    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [FW-1:0] w_fifo_din;
    logic [FW-1:0] w_fifo_dout;

    assign w_s_last     = r_mode_420 ? 4'(MCU_S_420 - 1) : 4'(MCU_S_444 - 1);
    assign w_s_step     = r_mode_420 ? 17'(MCU_S_420) : 17'(MCU_S_444);
    assign w_x          = r_mcu_x + {13'd0, r_col};
    assign w_y          = r_mcu_y + {13'd0, r_row};
    assign w_next_mcu_x = r_mcu_x + w_s_step;
    assign w_next_mcu_y = r_mcu_y + w_s_step;
    assign w_lin        = ({17'd0, w_y} * {18'd0, r_width}) + {17'd0, w_x};
    // Padding pixels of edge MCUs still advance the counters but are never written.
    assign w_in_bounds  = (w_x < {1'b0, r_width}) && (w_y < {1'b0, r_height});
    assign w_push_req   = (r_state == RUN) && pixel_valid && w_in_bounds;
    assign w_pop        = !w_empty && mem_ready;
    assign w_fifo_din   = {w_lin[ADDR_W-1:0], pack_pixel(r_in, g_in, b_in)};

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push_req),
        .wr_data (w_fifo_din),
        .rd_en   (w_pop),
        .rd_data (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_mode_420   <= 1'b0;
            r_mcu_x      <= '0;
            r_mcu_y      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_width    <= img_width;
                        r_height   <= img_height;
                        r_mode_420 <= mode_420;
                        r_mcu_x    <= '0;
                        r_mcu_y    <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if ((img_width == 16'd0) || (img_height == 16'd0)) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pixel_valid) begin
                        if (r_col == w_s_last) begin
                            r_col <= '0;
                            if (r_row == w_s_last) begin
                                r_row <= '0;
                                if (w_next_mcu_x >= {1'b0, r_width}) begin
                                    r_mcu_x <= '0;
                                    r_mcu_y <= w_next_mcu_y;
                                    if (w_next_mcu_y >= {1'b0, r_height}) begin
                                        r_state <= DRAIN;
                                    end
                                end else begin
                                    r_mcu_x <= w_next_mcu_x;
                                end
                            end else begin
                                r_row <= r_row + 4'd1;
                            end
                        end else begin
                            r_col <= r_col + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we     = !w_empty;
    assign mem_addr   = w_fifo_dout[FW-1:PIX_W];
    assign mem_wdata  = w_fifo_dout[PIX_W-1:0];
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_mcu_raster_writer.sv
// Directed self-checking bench for mcu_raster_writer; honours JPEG_RGB565_EN for expected pixel words.
module tb_mcu_raster_writer;
    import jpeg_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      img_width = '0;
    logic [15:0]      img_height = '0;
    logic             mode_420 = 1'b0;
    logic [7:0]       r_in = '0;
    logic [7:0]       g_in = '0;
    logic [7:0]       b_in = '0;
    logic             pixel_valid = 1'b0;
    logic             mem_we;
    logic [19:0]      mem_addr;
    logic [PIX_W-1:0] mem_wdata;
    logic             mem_ready = 1'b1;
    logic             busy;
    logic             frame_done;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    logic [19:0]      wr_addr_q [$];
    logic [PIX_W-1:0] wr_data_q [$];

    mcu_raster_writer #(.ADDR_W(20), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_width(img_width),
        .img_height(img_height), .mode_420(mode_420), .r_in(r_in), .g_in(g_in),
        .b_in(b_in), .pixel_valid(pixel_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record accepted writes away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%0d data=0x%0h", mem_addr, mem_wdata);
        end
        if (rst_n && frame_done) fd_count++;
    end

    function automatic logic [PIX_W-1:0] exp_pix(input logic [7:0] r, input logic [7:0] g,
                                                 input logic [7:0] b);
`ifdef JPEG_RGB565_EN
        return {r[7:3], g[7:2], b[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        fd_count = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_frame(input int w, input int h, input logic m420);
        img_width  = 16'(w);
        img_height = 16'(h);
        mode_420   = m420;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Pixel i carries r=i, g=~i, b=i^0x5A.
    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            r_in = 8'(i);
            g_in = ~8'(i);
            b_in = 8'(i) ^ 8'h5A;
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_we, busy, frame_done, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {mem_we, busy, frame_done, overflow});
        end
        checks++;
        if (mem_addr !== 20'd0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus got addr=%0h data=%0h exp 0/0", mem_addr, mem_wdata);
        end
        $display("test_reset done");
    endtask

    task automatic test_444_basic();
        bit ok;
        clear_mon();
        mem_ready = 1'b1;
        start_frame(8, 8, 1'b0);
        send_pixels(20);
        // start mid-frame must be ignored
        start = 1'b1;
        img_width = 16'd0;
        send_pixels(1);
        start = 1'b0;
        img_width = 16'd8;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored busy got=%b exp=1", busy);
        end
        for (int i = 21; i < 64; i++) begin
            pixel_valid = 1'b1;
            r_in = 8'(i); g_in = ~8'(i); b_in = 8'(i) ^ 8'h5A;
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout busy got=1 exp=0"); end
        checks++;
        if (wr_addr_q.size() != 64) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=64", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 64; i++) begin
            logic [7:0] pv;
            pv = (i == 20) ? 8'd0 : 8'(i);
            checks++;
            if (wr_addr_q[i] !== 20'(i)) begin
                errors++;
                $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], i);
            end
            if (i != 20) begin
                checks++;
                if (wr_data_q[i] !== exp_pix(pv, ~pv, pv ^ 8'h5A)) begin
                    errors++;
                    $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, wr_data_q[i],
                             exp_pix(pv, ~pv, pv ^ 8'h5A));
                end
            end
        end
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL basic_frame_done got=%0d exp=1", fd_count); end
        $display("test_444_basic done writes=%0d", wr_addr_q.size());
    endtask

    task automatic test_420_padding();
        bit ok;
        bit seen [200];
        int dup;
        clear_mon();
        mem_ready = 1'b1;
        start_frame(20, 10, 1'b1);
        send_pixels(512);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pad_timeout busy got=1 exp=0"); end
        checks++;
        if (wr_addr_q.size() != 200) begin
            errors++;
            $display("FAIL pad_count got=%0d exp=200", wr_addr_q.size());
        end
        checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== 20'd199) begin
            errors++;
            $display("FAIL pad_last_addr got=%0d exp=199",
                     wr_addr_q.size() ? wr_addr_q[wr_addr_q.size()-1] : 20'hFFFFF);
        end
        dup = 0;
        foreach (wr_addr_q[i]) begin
            if (wr_addr_q[i] >= 200 || seen[wr_addr_q[i]]) dup++;
            else seen[wr_addr_q[i]] = 1'b1;
        end
        checks++;
        if (dup != 0) begin errors++; $display("FAIL pad_unique bad=%0d exp=0", dup); end
        // first write of MCU 1 is pixel (16,0) => addr 16
        checks++;
        if (wr_addr_q.size() > 160 && wr_addr_q[160] !== 20'd16) begin
            errors++;
            $display("FAIL pad_mcu1_first got=%0d exp=16", wr_addr_q[160]);
        end
        checks++;
        if (fd_count != 1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL pad_done fd=%0d ovf=%b exp fd=1 ovf=0", fd_count, overflow);
        end
        $display("test_420_padding done writes=%0d", wr_addr_q.size());
    endtask

    task automatic test_overflow();
        bit ok;
        clear_mon();
        mem_ready = 1'b0;
        start_frame(16, 8, 1'b0);
        send_pixels(128);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 20'd0) begin
            errors++;
            $display("FAIL ovf_hold busy=%b ovf=%b we=%b addr=%0d exp 1 1 1 0",
                     busy, overflow, mem_we, mem_addr);
        end
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_no_write got=%0d exp=0", wr_addr_q.size());
        end
        mem_ready = 1'b1;
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_timeout busy got=1 exp=0"); end
        checks++;
        if (wr_addr_q.size() != 16) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=16", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
            int ea;
            ea = (i < 8) ? i : 16 + (i - 8);
            checks++;
            if (wr_addr_q[i] !== 20'(ea) || wr_data_q[i] !== exp_pix(8'(i), ~8'(i), 8'(i) ^ 8'h5A)) begin
                errors++;
                $display("FAIL ovf_entry[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h", i,
                         wr_addr_q[i], wr_data_q[i], ea, exp_pix(8'(i), ~8'(i), 8'(i) ^ 8'h5A));
            end
        end
        checks++;
        if (overflow !== 1'b1 || fd_count != 1) begin
            errors++;
            $display("FAIL ovf_sticky ovf=%b fd=%0d exp ovf=1 fd=1", overflow, fd_count);
        end
        $display("test_overflow done writes=%0d", wr_addr_q.size());
    endtask

    task automatic test_zero_width();
        clear_mon();
        mem_ready = 1'b1;
        start_frame(0, 8, 1'b0);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL zero_done fd=%b ovf=%b exp fd=1 ovf=0", frame_done, overflow);
        end
        @(posedge clk);
        #1;
        send_pixels(8);
        checks++;
        if (busy !== 1'b0 || wr_addr_q.size() != 0 || mem_we !== 1'b0 || fd_count != 1) begin
            errors++;
            $display("FAIL zero_idle busy=%b writes=%0d we=%b fd=%0d exp 0 0 0 1",
                     busy, wr_addr_q.size(), mem_we, fd_count);
        end
        $display("test_zero_width done");
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        clear_mon();
        mem_ready = 1'b0;
        start_frame(8, 8, 1'b0);
        send_pixels(30);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre ovf=%b busy=%b exp 1 1", overflow, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, frame_done, overflow} !== 4'b0000 || mem_addr !== 20'd0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL midrst_async flags=%b addr=%0h data=%0h exp 0000/0/0",
                     {mem_we, busy, frame_done, overflow}, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        clear_mon();
        start_frame(8, 8, 1'b0);
        send_pixels(64);
        wait_idle(200, ok);
        checks++;
        if (!ok || wr_addr_q.size() != 64) begin
            errors++;
            $display("FAIL midrst_frame ok=%b writes=%0d exp ok=1 writes=64", ok, wr_addr_q.size());
        end
        checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 20'd0 || wr_addr_q[wr_addr_q.size()-1] !== 20'd63) begin
            errors++;
            $display("FAIL midrst_addrs first/last wrong exp 0/63");
        end
        checks++;
        if (overflow !== 1'b0 || fd_count != 1) begin
            errors++;
            $display("FAIL midrst_clean ovf=%b fd=%0d exp 0 1", overflow, fd_count);
        end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_pixel_pack();
        bit ok;
        logic [PIX_W-1:0] exp_word;
`ifdef JPEG_RGB565_EN
        exp_word = 16'hFC00;
`else
        exp_word = 24'hFF8001;
`endif
        clear_mon();
        mem_ready = 1'b1;
        start_frame(1, 1, 1'b0);
        pixel_valid = 1'b1;
        r_in = 8'hFF; g_in = 8'h80; b_in = 8'h01;
        @(posedge clk);
        #1 pixel_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 20'd0 || mem_wdata !== exp_word) begin
            errors++;
            $display("FAIL pack_latency we=%b addr=%0d data=%0h exp we=1 addr=0 data=%0h",
                     mem_we, mem_addr, mem_wdata, exp_word);
        end
        send_pixels(63);
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_addr_q.size() != 1 || fd_count != 1) begin
            errors++;
            $display("FAIL pack_frame ok=%b writes=%0d fd=%0d exp 1 1 1", ok, wr_addr_q.size(), fd_count);
        end
        $display("test_pixel_pack done");
    endtask

    initial begin
        test_reset();
        test_444_basic();
        test_420_padding();
        test_overflow();
        test_zero_width();
        test_reset_mid_run();
        test_pixel_pack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
